dro_readout_deserializer: RTL and testbench
===========================================

# dro_readout_deserializer

Clocked receiver sitting directly downstream of the `dro` destructive-readout cell. It watches the cell's toggle-encoded `set`, `reset` (readout) and `out` lines, and turns each readout into one data bit: 1 if an `out` pulse follows within a window, else 0. It packs the bits into WIDTH-bit words behind a valid/ready handshake. It also flags set-to-readout spacing violations, which are the cycle-domain counterpart of the cell's SDF setup check.

## Interface
- WIDTH, 8: bits per output word (2..32).
- WINDOW, 4: cycles after a detected readout during which an `out` pulse counts as a 1 (1..15).
- MIN_SEP, 3: minimum cycles from a detected `set` pulse to a detected readout (0..15; 0 disables the check).

Ports:
- clk  in  1  sampling clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- set  in  1  DRO set line, toggle-encoded: every transition is one pulse.
- reset  in  1  DRO readout line, toggle-encoded.
- out  in  1  DRO output line, toggle-encoded.
- word  out  WIDTH  assembled word; first-received bit in bit 0.
- word_valid  out  1  word holds an unconsumed word.
- word_ready  in  1  consumer accepts word when high with word_valid.
- violation  out  1  one-cycle pulse on a spacing violation.
- violation_seen  out  1  sticky OR of violation; cleared only by rst.
- spurious_out  out  1  one-cycle pulse when an `out` pulse arrives outside any window.
- overrun  out  1  sticky; a completed word was dropped because the holding register was full.

## Operation
- Pulse detection: each input is registered, and pulse = current XOR previous registered value. While rst is high, the previous-value registers load the live inputs, so no pulse is ever detected in the first cycle after reset.
- FSM, states IDLE and WINDOW:
  - IDLE + readout pulse: go to WINDOW, win_cnt=0, cur_bit=0.
  - WINDOW + out pulse: cur_bit=1.
  - WINDOW, win_cnt==WINDOW-1 with no new readout: commit cur_bit (OR this cycle's out pulse), go to IDLE.
  - WINDOW + new readout pulse: commit cur_bit (OR this cycle's out pulse) and restart the window with win_cnt=0, cur_bit=0. The state stays WINDOW.
- Commit: shift the bit into the shift register at index bit_cnt, then increment bit_cnt. When bit_cnt reaches WIDTH, transfer the shift register to word and wrap bit_cnt to 0.
  - If word_valid=1 and word_ready=0 in the transfer cycle, the new word is dropped, overrun is set, and word is left unchanged.
  - A same-cycle accept and transfer is legal: word takes the new value and word_valid stays 1.
- Handshake: word_valid falls the cycle after word_valid&&word_ready, unless a transfer happens in the same cycle. word is stable while word_valid=1.
- Spacing check: since_set saturates at 15, resets to 0 on a set pulse, and increments otherwise.
  - A readout pulse with since_set<MIN_SEP (evaluated before this cycle's update) pulses violation. The bit is still captured normally.
  - Set and readout pulses in the same cycle count as since_set=0, so they always violate when MIN_SEP>0.
- spurious_out: an out pulse in IDLE that is not accompanied by a readout pulse in the same cycle.
- Reset values: word=0, word_valid=0, violation=0, violation_seen=0, spurious_out=0, overrun=0. Internally, state=IDLE, bit_cnt=0, since_set=15.
- Asserting rst mid-word or mid-window discards all partial data.

## Timing
- Input edge to detected pulse: 1 cycle (the input register).
- A readout detected in cycle n opens a window covering detected out pulses in cycles n..n+WINDOW-1. The bit commits in cycle n+WINDOW-1.
- The last bit commits in cycle c; word_valid and word are visible in cycle c+1.
- violation and spurious_out are registered: they go high 1 cycle after the triggering detected pulse, for exactly 1 cycle.
- Throughput is one bit per readout. Back-to-back readouts at 1-cycle spacing are legal; each bit then reflects only its own single-cycle window.

## Structure
- Package `dro_rx_pkg` holds:
  - the state enum {IDLE, WINDOW};
  - a SAT_MAX=15 constant;
  - widths for the win_cnt and since_set counters (4 bits each).
- Sub-module `sfq_toggle_detect` (one instance per input line): input register, previous-value register, XOR pulse output, and rst-load behaviour.
- The top level contains the FSM, shift/word register, spacing counter and flags.

## Test plan
- Reset release, inputs idle with set=1 at deassert: no pulse detected; all outputs are 0 for 20 cycles.
- WIDTH=8, WINDOW=4: eight readouts spaced 10 cycles apart, with out toggled 2 cycles after readouts 0, 2, 5 and 7 → word=8'hA5, word_valid=1 one cycle after the last commit. Assert word_ready for one cycle → word_valid=0.
- MIN_SEP=3: set toggle followed by a reset toggle 2 cycles later → violation pulses once and violation_seen=1. Repeat with a 3-cycle gap → no violation.
- Out toggle with no open window → spurious_out=1 for one cycle. Out toggle 5 cycles after a readout (WINDOW=4) → spurious_out, and the bit is 0.
- Two full words with word_ready held 0 → first word retained, overrun=1. Then word_ready=1 on the exact cycle of a transfer → the new word is loaded, word_valid stays 1, and overrun does not set.
- rst asserted after 5 bits → bit_cnt=0. Eight further readouts with out → a clean 8'hFF word with no leftover bits.

Source files
------------

// File: rtl/dro_rx_pkg.sv
// dro_rx_pkg: shared types and constants for the DRO readout deserializer
package dro_rx_pkg;
  typedef enum logic {S_IDLE, S_WINDOW} state_e;
  localparam int SAT_MAX = 15;
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/sfq_toggle_detect.sv
// sfq_toggle_detect: turns a toggle-encoded line into a one-cycle pulse
module sfq_toggle_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);
  logic in_q, prev_q;
  // loading the live level during reset keeps the first post-reset cycle pulse-free
  always_ff @(posedge clk) begin
    in_q   <= d_i;
    prev_q <= rst ? d_i : in_q;
  end
  assign pulse_o = in_q ^ prev_q;
endmodule

// File: rtl/dro_readout_deserializer.sv
// dro_readout_deserializer: turns DRO readouts into bits, packs them into words,
// and flags set-to-readout spacing violations
module dro_readout_deserializer
  import dro_rx_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int WINDOW  = 4,
  parameter int MIN_SEP = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             reset,
  input  logic             out,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             violation,
  output logic             violation_seen,
  output logic             spurious_out,
  output logic             overrun
);
  localparam int BC_W = $clog2(WIDTH);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);
  localparam cnt_t WIN_LAST = cnt_t'(WINDOW - 1);
  localparam cnt_t MIN_SEP_C = cnt_t'(MIN_SEP);
  logic set_p, rd_p, out_p;
  state_e state_q, state_d;
  cnt_t win_cnt_q, win_cnt_d, since_set_q, since_set_d, eff_since;
  logic cur_bit_q, cur_bit_d;
  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d, word_q, word_d, filled;
  logic word_valid_q, word_valid_d, viol_q, viol_d, viol_seen_q, viol_seen_d;
  logic spur_q, spur_d, overrun_q, overrun_d;
  logic in_win, end_win, commit, commit_bit, xfer, drop;

  sfq_toggle_detect u_set (.clk(clk), .rst(rst), .d_i(set),   .pulse_o(set_p));
  sfq_toggle_detect u_rd  (.clk(clk), .rst(rst), .d_i(reset), .pulse_o(rd_p));
  sfq_toggle_detect u_out (.clk(clk), .rst(rst), .d_i(out),   .pulse_o(out_p));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      win_cnt_q   <= '0;
      cur_bit_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      word_valid_q <= 1'b0;
      since_set_q <= cnt_t'(SAT_MAX);
      viol_q      <= 1'b0;
      viol_seen_q <= 1'b0;
      spur_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      cur_bit_q   <= cur_bit_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      word_valid_q <= word_valid_d;
      since_set_q <= since_set_d;
      viol_q      <= viol_d;
      viol_seen_q <= viol_seen_d;
      spur_q      <= spur_d;
      overrun_q   <= overrun_d;
    end
  end

  // the readout cycle itself is window slot 0, so a 1-cycle window never leaves IDLE
  always_comb begin
    in_win  = state_q == S_WINDOW;
    end_win = in_win && (rd_p || win_cnt_q == WIN_LAST);
    state_d = (rd_p && WINDOW > 1) ? S_WINDOW : (end_win ? S_IDLE : state_q);
  end

  always_comb begin
    commit       = end_win || (rd_p && WINDOW == 1);
    commit_bit   = out_p || (in_win && cur_bit_q);
    xfer         = commit && bit_cnt_q == LAST_BIT;
    filled       = shift_q | (WIDTH'(commit_bit) << bit_cnt_q);
    drop         = xfer && word_valid_q && !word_ready;
    win_cnt_d    = rd_p ? cnt_t'(1) : (in_win ? win_cnt_q + 1'b1 : win_cnt_q);
    cur_bit_d    = rd_p ? (!in_win && out_p) : (in_win && (cur_bit_q || out_p));
    bit_cnt_d    = !commit ? bit_cnt_q : (xfer ? '0 : bit_cnt_q + 1'b1);
    shift_d      = !commit ? shift_q : (xfer ? '0 : filled);
    word_d       = (xfer && !drop) ? filled : word_q;
    word_valid_d = (xfer && !drop) || (word_valid_q && !word_ready);
    overrun_d    = overrun_q || drop;
    eff_since    = set_p ? '0 : since_set_q;
    since_set_d  = (eff_since == cnt_t'(SAT_MAX)) ? eff_since : eff_since + 1'b1;
    viol_d       = rd_p && (eff_since < MIN_SEP_C);
    viol_seen_d  = viol_seen_q || viol_d;
    spur_d       = !in_win && out_p && !rd_p;
  end

  assign word           = word_q;
  assign word_valid     = word_valid_q;
  assign violation      = viol_q;
  assign violation_seen = viol_seen_q;
  assign spurious_out   = spur_q;
  assign overrun        = overrun_q;
endmodule

// File: tb/tb_dro_readout_deserializer.sv
// tb_dro_readout_deserializer: directed stimulus with a word scoreboard and flag checks
module tb_dro_readout_deserializer;
  logic clk = 1'b0, rst = 1'b1, set_l = 1'b1, rdo = 1'b0, out_l = 1'b0, word_ready = 1'b0;
  logic [7:0] word;
  logic word_valid, violation, violation_seen, spurious_out, overrun;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  dro_readout_deserializer #(.WIDTH(8), .WINDOW(4), .MIN_SEP(3)) dut (
    .clk(clk), .rst(rst), .set(set_l), .reset(rdo), .out(out_l),
    .word(word), .word_valid(word_valid), .word_ready(word_ready),
    .violation(violation), .violation_seen(violation_seen),
    .spurious_out(spurious_out), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected word: got %0h expected none", word);
      end else chk("word", {24'd0, word}, {24'd0, exp_q.pop_front()});
    end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input bit b, input bit rdy, input bit chkv);
    rdo = ~rdo;
    cyc(2);
    if (b) out_l = ~out_l;
    cyc(2);
    if (rdy) word_ready = 1'b1;
    if (chkv) chk("valid before last commit", word_valid, 0);
    cyc(1);
    if (rdy) word_ready = 1'b0;
    if (chkv) chk("valid after last commit", word_valid, 1);
    cyc(5);
  endtask

  task automatic send(input logic [7:0] w, input bit push, input bit rdy_last, input bit chk_last);
    for (int i = 0; i < 8; i++) rd(w[i], rdy_last && i == 7, chk_last && i == 7);
    if (push) exp_q.push_back(w);
  endtask

  task automatic accept();
    word_ready = 1'b1;
    cyc(1);
    word_ready = 1'b0;
    chk("valid after accept", word_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("flags after reset", {word_valid, violation_seen, overrun}, 0);
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("idle outputs", {word, word_valid, violation, violation_seen, spurious_out, overrun}, 0);
    end
    send(8'hA5, 1, 0, 1);
    chk("word A5 held", word, 8'hA5);
    accept();
    do_reset();
    set_l = ~set_l;
    cyc(2);
    rdo = ~rdo;
    cyc(2);
    chk("violation gap 2", violation, 1);
    cyc(1);
    chk("violation one cycle", violation, 0);
    chk("violation_seen", violation_seen, 1);
    cyc(6);
    set_l = ~set_l;
    cyc(3);
    rdo = ~rdo;
    cyc(2);
    chk("no violation gap 3", violation, 0);
    cyc(1);
    chk("no violation gap 3 late", violation, 0);
    cyc(6);
    set_l = ~set_l;
    rdo = ~rdo;
    cyc(2);
    chk("violation same cycle", violation, 1);
    cyc(6);
    do_reset();
    out_l = ~out_l;
    cyc(2);
    chk("spurious idle", spurious_out, 1);
    cyc(1);
    chk("spurious one cycle", spurious_out, 0);
    rdo = ~rdo;
    cyc(5);
    out_l = ~out_l;
    cyc(2);
    chk("spurious late out", spurious_out, 1);
    cyc(6);
    for (int i = 0; i < 7; i++) rd(1, 0, 0);
    exp_q.push_back(8'hFE);
    accept();
    do_reset();
    send(8'h3C, 1, 0, 0);
    send(8'h96, 1, 1, 0);
    chk("valid after same-cycle transfer", word_valid, 1);
    chk("no overrun on same-cycle accept", overrun, 0);
    send(8'h5A, 0, 0, 0);
    chk("overrun set", overrun, 1);
    chk("word retained", word, 8'h96);
    accept();
    do_reset();
    for (int i = 0; i < 5; i++) rd(1, 0, 0);
    do_reset();
    for (int i = 0; i < 7; i++) rd(1, 0, 0);
    chk("no word from leftover bits", word_valid, 0);
    rd(1, 0, 0);
    exp_q.push_back(8'hFF);
    chk("valid after clean word", word_valid, 1);
    accept();
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
